mul_seq: RTL and testbench
==========================

# mul_seq

Parametrised iterative shift-add multiplier; successor to the 8-bit combinational array multiplier. Produces the full 2×WIDTH-bit product, with optional signed operation. Operands enter and results leave over valid/ready handshakes, so the block sits between the decode/issue stage and the ALU writeback path. A multi-cycle result costs a fraction of the area of the array multiplier.

## Interface
- `WIDTH`, default 8: operand width; legal range ≥ 2.
- `CNT_W`, default $clog2(WIDTH+1): iteration counter width; derived, never overridden.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can accept operands.
- `in_a` in WIDTH: multiplicand.
- `in_b` in WIDTH: multiplier.
- `in_signed` in 1: treat operands as two's complement; ignored without `MUL_SIGNED_EN`.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out_product` out 2*WIDTH: full product.
- `out_ovf` out 1: upper half is not the zero/sign extension of the lower half, meaning a WIDTH-bit truncation would be wrong.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterating.
  - DONE: `out_valid`=1.
- Accept: `in_valid && in_ready` at an edge.
  - Latch operand magnitudes into the multiplicand register and the multiplier shift register.
  - Latch sign flag = `in_signed & (a[MSB] ^ b[MSB])`.
  - Clear the accumulator; set count to WIDTH; go to BUSY.
- BUSY, per edge:
  - If multiplier LSB = 1, add the multiplicand into the accumulator upper half (WIDTH+1-bit add, carry kept).
  - Shift the {carry, accumulator, multiplier} chain right by 1.
  - Decrement count. When count reaches 1, the next edge completes the last step and enters DONE.
- DONE: `out_product` = accumulator, negated (two's complement, 2*WIDTH bits) if the sign flag is set. `out_ovf` is computed from the final product.
- Leaving DONE:
  - If `out_ready`=1, leave DONE.
  - If `in_valid` is also 1 in that cycle, accept new operands directly (DONE→BUSY).
  - Otherwise go to IDLE.
- `in_ready` = IDLE | (DONE & `out_ready`). Operands arriving during BUSY are never accepted.
- Signed magnitude: |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned WIDTH bits. The product (−2^(W−1))² = 2^(2W−2) fits signed 2W bits, so there is no overflow within `out_product`.
- Unsigned multiply: magnitude = operand; sign flag = 0.
- `out_product` and `out_ovf` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `out_product`=0, `out_ovf`=0, count=0, sign flag=0.
- Reset mid-BUSY or in DONE: the operation is aborted and the result discarded; IDLE on the next cycle.
- Latency: accept at edge k → `out_valid` high after edge k+WIDTH. Fixed; no early termination on zero operands.
- Throughput: one result per WIDTH+1 cycles with `out_ready` held high and `in_valid` continuous.
- Backpressure: DONE is held indefinitely while `out_ready`=0.
- `out_product` is registered; `out_ovf` is registered at the DONE entry. No combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready`, and only in DONE.

## Configuration
- `MUL_SIGNED_EN` defined:
  - Operand abs and sign-flag logic and the final negation are compiled in.
  - `in_signed`=1 gives a two's-complement product.
  - `out_ovf` compares the upper half with sign extension of bit WIDTH−1 when signed, and with zero when unsigned.
- `MUL_SIGNED_EN` undefined:
  - Abs/negate logic is absent and `in_signed` is ignored.
  - All operations are unsigned.
  - `out_ovf` = |upper half|.

## Structure
- Package `mul_pkg`: state enum `mul_state_t` (IDLE, BUSY, DONE) and function `mul_cnt_w(width)`.
- Sub-module `mul_step`: combinational one-iteration datapath.
  - Inputs: accumulator, multiplier register, multiplicand.
  - Output: next accumulator and next multiplier register.
  - Instantiated once by `mul_seq`, which owns the FSM, counter, handshake and sign handling.

## Test plan
- WIDTH=8, unsigned, a=13, b=11: `out_product`=0x008F, `out_ovf`=0, `out_valid` exactly 8 cycles after accept.
- Unsigned a=255, b=255: `out_product`=0xFE01, `out_ovf`=1. With a=0 or b=0: product 0, latency still 8.
- `MUL_SIGNED_EN`, `in_signed`=1:
  - a=0xFD (−3), b=0x05: product 0xFFF1, `out_ovf`=0.
  - a=b=0x80: product 0x4000, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. Result stable, `in_ready`=0, `in_valid` pulses ignored. Raise `out_ready` with `in_valid`=1: new operands accepted in the same cycle.
- Assert `rst` 3 cycles into BUSY: next cycle `in_ready`=1 and `out_valid`=0. A new 7×6 then yields 0x002A.
- Random sweep, WIDTH=8 and WIDTH=16, both modes, randomised `in_valid`/`out_ready`: every product matches the reference model, and no result is lost or duplicated.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Width of a down-counter that must hold the value `width`.
    function automatic int unsigned mul_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditional add into the accumulator upper half,
// then a right shift of the {carry, accumulator, multiplier} chain.
module mul_step
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mplier_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   mplier_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
        if (mplier_i[0]) begin
            sum = sum + {1'b0, mcand_i};
        end
        // The carry lands in the accumulator MSB after the shift.
        acc_o    = {sum, acc_i[WIDTH-1:1]};
        mplier_o = {acc_i[0], mplier_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier with valid/ready handshakes.
// Signed operation is compiled in only when MUL_SIGNED_EN is defined.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_ovf
);

    localparam int unsigned CNT_W = mul_cnt_w(WIDTH);

    mul_state_t           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]     step_mplier;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   fin_prod;
    logic [WIDTH-1:0]     fin_ext;
    logic                 fin_ovf;

`ifdef MUL_SIGNED_EN
    logic neg_q, neg_d;
    logic smode_q, smode_d;

    // Operand magnitudes; |-2^(WIDTH-1)| still fits WIDTH unsigned bits.
    always_comb begin
        mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    end
`else
    logic unused_in_signed;
    assign unused_in_signed = in_signed;

    always_comb begin
        mag_a = in_a;
        mag_b = in_b;
    end
`endif

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mplier_i (mplier_q),
        .mcand_i  (mcand_q),
        .acc_o    (step_acc),
        .mplier_o (step_mplier)
    );

    // Final product and overflow, taken from the last iteration's result.
    always_comb begin
        fin_prod = step_acc;
        fin_ext  = '0;
`ifdef MUL_SIGNED_EN
        if (neg_q) begin
            fin_prod = -step_acc;
        end
        if (smode_q) begin
            fin_ext = {WIDTH{fin_prod[WIDTH-1]}};
        end
`endif
        fin_ovf = (fin_prod[2*WIDTH-1:WIDTH] != fin_ext);
    end

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        ovf_d       = ovf_q;
        in_ready    = 1'b0;
`ifdef MUL_SIGNED_EN
        neg_d       = neg_q;
        smode_d     = smode_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                acc_d    = step_acc;
                mplier_d = step_mplier;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    prod_d  = fin_prod;
                    ovf_d   = fin_ovf;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_valid && in_ready) begin
            state_d  = BUSY;
            acc_d    = '0;
            mplier_d = mag_b;
            mcand_d  = mag_a;
            cnt_d    = CNT_W'(WIDTH);
`ifdef MUL_SIGNED_EN
            neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            smode_d  = in_signed;
`endif
        end

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_q       <= 1'b0;
            smode_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
`ifdef MUL_SIGNED_EN
            neg_q       <= neg_d;
            smode_q     <= smode_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_product = prod_q;
    assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomised-handshake bench for mul_seq at WIDTH=8 and WIDTH=16.
module tb_mul_seq;

`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, out_ovf8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_product8;

    logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, out_ovf16;
    logic [15:0] in_a16, in_b16;
    logic [31:0] out_product16;

    int errors = 0;
    int checks = 0;

    typedef logic [16:0] exp_t;
    exp_t exp_q[$];

    mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_signed(in_signed8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_product(out_product8), .out_ovf(out_ovf8)
    );

    mul_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_signed(in_signed16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_product(out_product16), .out_ovf(out_ovf16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiply, signed only when the build supports it.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int          ia;
        int          ib;
        logic        se;
        logic [15:0] p;
        logic        o;
        se = s & SIGNED_EN;
        ia = se ? int'($signed(a)) : int'(a);
        ib = se ? int'($signed(b)) : int'(b);
        p  = 16'(ia * ib);
        o  = se ? (p[15:8] != {8{p[7]}}) : (p[15:8] != 8'h00);
        return {o, p};
    endfunction

    task automatic wait_valid8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid8 && cyc < 40);
    endtask

    task automatic wait_valid16(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid16 && cyc < 60);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] ep, input logic eo);
        int cyc;
        @(negedge clk);
        in_a8 = a; in_b8 = b; in_signed8 = s; in_valid8 = 1'b1; out_ready8 = 1'b0;
        #1 check({tag, " in_ready"}, 64'(in_ready8), 64'(1));
        @(posedge clk); #1 in_valid8 = 1'b0;
        wait_valid8(cyc);
        check({tag, " latency"}, 64'(cyc), 64'(8));
        check({tag, " product"}, 64'(out_product8), 64'(ep));
        check({tag, " ovf"}, 64'(out_ovf8), 64'(eo));
        @(negedge clk) out_ready8 = 1'b1;
        @(posedge clk); #1;
        check({tag, " drained"}, 64'(out_valid8), 64'(0));
        out_ready8 = 1'b0;
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] ep, input logic eo);
        int cyc;
        @(negedge clk);
        in_a16 = a; in_b16 = b; in_signed16 = s; in_valid16 = 1'b1; out_ready16 = 1'b0;
        @(posedge clk); #1 in_valid16 = 1'b0;
        wait_valid16(cyc);
        check({tag, " latency"}, 64'(cyc), 64'(16));
        check({tag, " product"}, 64'(out_product16), 64'(ep));
        check({tag, " ovf"}, 64'(out_ovf16), 64'(eo));
        @(negedge clk) out_ready16 = 1'b1;
        @(posedge clk); #1 out_ready16 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        int   sent;
        int   got;
        exp_t e;

        rst = 1'b1;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; out_ready8 = 1'b0;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0; out_ready16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready8), 64'(1));
        check("reset out_valid", 64'(out_valid8), 64'(0));
        check("reset product", 64'(out_product8), 64'(0));
        check("reset ovf", 64'(out_ovf8), 64'(0));
        @(negedge clk) rst = 1'b0;

        op8("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
        op8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        op8("a_zero", 8'h00, 8'd200, 1'b0, 16'h0000, 1'b0);
        op8("b_zero", 8'd77, 8'h00, 1'b0, 16'h0000, 1'b0);
        op8("u16x16", 8'd16, 8'd16, 1'b0, 16'h0100, 1'b1);
`ifdef MUL_SIGNED_EN
        op8("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        op8("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        op8("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        op8("s_80x01", 8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);
        op8("s_off_FDx5", 8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
`else
        op8("ign_FDx5", 8'hFD, 8'h05, 1'b1, 16'h04F1, 1'b1);
        op8("ign_80x01", 8'h80, 8'h01, 1'b1, 16'h0080, 1'b0);
`endif

        // Backpressure: result held, operands refused, then DONE->BUSY hand-over.
        @(negedge clk);
        in_a8 = 8'd13; in_b8 = 8'd11; in_signed8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1 in_valid8 = 1'b0;
        wait_valid8(cyc);
        check("bp latency", 64'(cyc), 64'(8));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid8 = (i % 2 == 0); in_a8 = 8'hAA; in_b8 = 8'(i + 3);
            #1 check("bp in_ready low", 64'(in_ready8), 64'(0));
            @(posedge clk); #1;
            check("bp out_valid held", 64'(out_valid8), 64'(1));
            check("bp product held", 64'(out_product8), 64'(16'h008F));
            check("bp ovf held", 64'(out_ovf8), 64'(0));
        end
        @(negedge clk);
        in_a8 = 8'd7; in_b8 = 8'd6; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1 check("bp in_ready follows out_ready", 64'(in_ready8), 64'(1));
        @(posedge clk); #1;
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        check("bp handover out_valid", 64'(out_valid8), 64'(0));
        wait_valid8(cyc);
        check("bp handover latency", 64'(cyc), 64'(8));
        check("bp handover product", 64'(out_product8), 64'(16'h002A));
        @(negedge clk) out_ready8 = 1'b1;
        @(posedge clk); #1 out_ready8 = 1'b0;

        // Reset three cycles into BUSY.
        @(negedge clk);
        in_a8 = 8'd200; in_b8 = 8'd3; in_valid8 = 1'b1;
        @(posedge clk); #1 in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy in_ready low", 64'(in_ready8), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst busy in_ready", 64'(in_ready8), 64'(1));
        check("rst busy out_valid", 64'(out_valid8), 64'(0));
        check("rst busy product", 64'(out_product8), 64'(0));
        op8("post_rst_7x6", 8'd7, 8'd6, 1'b0, 16'h002A, 1'b0);

        // Reset while holding a result in DONE.
        @(negedge clk);
        in_a8 = 8'd9; in_b8 = 8'd9; in_valid8 = 1'b1;
        @(posedge clk); #1 in_valid8 = 1'b0;
        wait_valid8(cyc);
        check("done product", 64'(out_product8), 64'(16'h0051));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst done out_valid", 64'(out_valid8), 64'(0));
        check("rst done in_ready", 64'(in_ready8), 64'(1));

        op16("w16_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1);
        op16("w16_300x200", 16'd300, 16'd200, 1'b0, 32'h0000_EA60, 1'b0);
`ifdef MUL_SIGNED_EN
        op16("w16_s_m1x2", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE, 1'b0);
`else
        op16("w16_ign_m1x2", 16'hFFFF, 16'h0002, 1'b1, 32'h0001_FFFE, 1'b1);
`endif

        // Random operands and handshakes; every accepted pair must come out once, in order.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid8  = ($urandom_range(0, 2) != 0);
            out_ready8 = 1'($urandom_range(0, 1));
            in_a8      = 8'($urandom);
            in_b8      = 8'($urandom);
            in_signed8 = 1'($urandom_range(0, 1));
            #1;
            if (out_valid8 && out_ready8) begin
                got++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sweep product", 64'(out_product8), 64'(e[15:0]));
                    check("sweep ovf", 64'(out_ovf8), 64'(e[16]));
                end
            end
            if (in_valid8 && in_ready8) begin
                exp_q.push_back(model8(in_a8, in_b8, in_signed8));
                sent++;
            end
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (out_valid8 && out_ready8) begin
                got++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("drain product", 64'(out_product8), 64'(e[15:0]));
                    check("drain ovf", 64'(out_ovf8), 64'(e[16]));
                end
            end
            @(negedge clk);
        end
        check("sweep result count", 64'(got), 64'(sent));
        check("sweep queue empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
